// File: rtl/rs_pkg.sv
// Shared types and constants for the Tomasulo reservation station.
package rs_pkg;

   localparam int TAG_W = 5;

   typedef enum logic [3:0] {
      MAJ_ALU = 4'h1,
      MAJ_MUL = 4'h2,
      MAJ_LSU = 4'h3,
      MAJ_BRU = 4'h4
   } major_e;

   // Per-entry control/tag state; busy bits and operand values live beside it.
   typedef struct packed {
      logic [3:0]       minor;
      logic [TAG_W-1:0] dest;
      logic             rdy1;
      logic [TAG_W-1:0] tag1;
      logic             rdy2;
      logic [TAG_W-1:0] tag2;
   } rs_entry_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rs_select.sv
// One-hot picker over an eligible mask: lowest index, or lowest age rank
// when RS_OLDEST_FIRST_EN is defined.
module rs_select
   import rs_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
`ifdef RS_OLDEST_FIRST_EN
   input  logic [N-1:0][clog2(N)-1:0] rank,
`endif
   output logic [N-1:0]         grant,
   output logic                 valid
);

`ifdef RS_OLDEST_FIRST_EN
   localparam int RW = clog2(N);
   logic [RW-1:0] best;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      best  = '0;
      for (int i = 0; i < N; i++) begin
         if (eligible[i] && (!valid || rank[i] < best)) begin
            grant    = '0;
            grant[i] = 1'b1;
            best     = rank[i];
            valid    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (eligible[i] && !valid) begin
            grant[i] = 1'b1;
            valid    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: accepts dispatched ops, snoops the CDB, issues
// ready entries to one FU. Optional age-ordered issue via RS_OLDEST_FIRST_EN.
module reservation_station
   import rs_pkg::*;
#(
   parameter int         ENTRIES  = 4,
   parameter logic [3:0] RS_MAJOR = MAJ_ALU,
   parameter int         DATA_W   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dispatch_valid_in,
   input  logic [3:0]        MajorOpcode_in,
   input  logic [3:0]        MinorOpcode_in,
   input  logic [TAG_W-1:0]  Destination_in,
   input  logic              src1_ready_in,
   input  logic              src2_ready_in,
   input  logic [TAG_W-1:0]  src1_tag_in,
   input  logic [TAG_W-1:0]  src2_tag_in,
   input  logic [DATA_W-1:0] src1_value_in,
   input  logic [DATA_W-1:0] src2_value_in,
   output logic              stall_out,
   input  logic              cdb_valid_in,
   input  logic [TAG_W-1:0]  cdb_tag_in,
   input  logic [DATA_W-1:0] cdb_value_in,
   output logic              issue_valid_out,
   input  logic              issue_ready_in,
   output logic [3:0]        issue_minor_out,
   output logic [TAG_W-1:0]  issue_dest_out,
   output logic [DATA_W-1:0] issue_a_out,
   output logic [DATA_W-1:0] issue_b_out
);

   localparam int IW = clog2(ENTRIES);
   localparam int OW = IW + 1;

   logic [ENTRIES-1:0] busy;
   rs_entry_t          ent  [ENTRIES];
   logic [DATA_W-1:0]  val1 [ENTRIES];
   logic [DATA_W-1:0]  val2 [ENTRIES];
   logic [OW-1:0]      occ;
   logic               held_vld;
   logic [ENTRIES-1:0] held_grant;

   logic               match;
   logic               full;
   logic               accept;
   logic               fire;
   logic [ENTRIES-1:0] free_oh;
   logic [ENTRIES-1:0] eligible;
   logic [ENTRIES-1:0] pick_grant;
   logic               pick_valid;
   logic [ENTRIES-1:0] sel_grant;
   logic               in1_rdy;
   logic               in2_rdy;
   logic [DATA_W-1:0]  in1_val;
   logic [DATA_W-1:0]  in2_val;

   assign match     = dispatch_valid_in && (MajorOpcode_in == RS_MAJOR);
   assign full      = (occ == OW'(ENTRIES));
   assign accept    = match && !full;
   assign stall_out = match && full;

   // An operand whose producer broadcasts in the dispatch cycle is captured here,
   // since the entry does not exist yet to snoop that broadcast.
   assign in1_rdy = src1_ready_in || (cdb_valid_in && src1_tag_in == cdb_tag_in);
   assign in2_rdy = src2_ready_in || (cdb_valid_in && src2_tag_in == cdb_tag_in);
   assign in1_val = src1_ready_in ? src1_value_in : cdb_value_in;
   assign in2_val = src2_ready_in ? src2_value_in : cdb_value_in;

   always_comb begin
      free_oh = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!busy[i] && free_oh == '0) free_oh[i] = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         eligible[i] = busy[i] && ent[i].rdy1 && ent[i].rdy2;
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   logic [ENTRIES-1:0][IW-1:0] rank;
   logic [IW-1:0]              freed_rank;

   rs_select #(.N(ENTRIES)) u_select (
      .eligible (eligible),
      .rank     (rank),
      .grant    (pick_grant),
      .valid    (pick_valid)
   );
`else
   rs_select #(.N(ENTRIES)) u_select (
      .eligible (eligible),
      .grant    (pick_grant),
      .valid    (pick_valid)
   );
`endif

   // A stalled grant is held until it fires so the FU sees a stable offer.
   assign sel_grant       = held_vld ? held_grant : pick_grant;
   assign issue_valid_out = held_vld || pick_valid;
   assign fire            = issue_valid_out && issue_ready_in;

   always_comb begin
      issue_minor_out = '0;
      issue_dest_out  = '0;
      issue_a_out     = '0;
      issue_b_out     = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (sel_grant[i]) begin
            issue_minor_out = issue_minor_out | ent[i].minor;
            issue_dest_out  = issue_dest_out  | ent[i].dest;
            issue_a_out     = issue_a_out     | val1[i];
            issue_b_out     = issue_b_out     | val2[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy       <= '0;
         occ        <= '0;
         held_vld   <= 1'b0;
         held_grant <= '0;
      end else begin
         busy <= (busy & ~(fire ? sel_grant : '0)) | (accept ? free_oh : '0);
         occ  <= occ + OW'(accept) - OW'(fire);
         if (fire) begin
            held_vld <= 1'b0;
         end else if (issue_valid_out) begin
            held_vld   <= 1'b1;
            held_grant <= sel_grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (accept && free_oh[i]) begin
            ent[i] <= '{minor: MinorOpcode_in, dest: Destination_in,
                        rdy1: in1_rdy, tag1: src1_tag_in,
                        rdy2: in2_rdy, tag2: src2_tag_in};
            val1[i] <= in1_val;
            val2[i] <= in2_val;
         end else begin
            if (cdb_valid_in && !ent[i].rdy1 && ent[i].tag1 == cdb_tag_in) begin
               ent[i].rdy1 <= 1'b1;
               val1[i]     <= cdb_value_in;
            end
            if (cdb_valid_in && !ent[i].rdy2 && ent[i].tag2 == cdb_tag_in) begin
               ent[i].rdy2 <= 1'b1;
               val2[i]     <= cdb_value_in;
            end
         end
      end
   end

`ifdef RS_OLDEST_FIRST_EN
   always_comb begin
      freed_rank = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (sel_grant[i]) freed_rank = freed_rank | rank[i];
      end
   end

   // New entries rank behind every survivor; survivors younger than the freed
   // entry close the gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rank <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (accept && free_oh[i]) begin
               rank[i] <= IW'(occ - OW'(fire));
            end else if (fire && busy[i] && !sel_grant[i] && rank[i] > freed_rank) begin
               rank[i] <= rank[i] - 1'b1;
            end
         end
      end
   end
`endif

endmodule
